// File: rtl/fir_decim_out.sv
// Decimate FIR/MAC samples, round and saturate them, and queue the results in a small FIFO.
// 2-edge latency from a selected din to dout_valid; a full FIFO with no pop drops the sample and sets ovf_flag.
module fir_decim_out #(
   parameter int WIDTH_IN        = 16,
   parameter int WIDTH_OUT       = 8,
   parameter int SHIFT           = 4,
   parameter int DECIM           = 4,
   parameter int LOG2_DECIM      = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int LOG2_FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH_IN-1:0]  din,
   input  logic                 din_valid,
   output logic [WIDTH_OUT-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 sat_flag,
   output logic                 ovf_flag,
   input  logic                 flag_clr
);

   localparam int WS = WIDTH_IN + 1;
   localparam logic signed [WS-1:0] RND  = WS'(1 << (SHIFT - 1));
   localparam logic signed [WS-1:0] MAXV = WS'((1 << (WIDTH_OUT - 1)) - 1);
   localparam logic signed [WS-1:0] MINV = WS'(-(1 << (WIDTH_OUT - 1)));

   logic [LOG2_DECIM-1:0]        phase;
   logic                         sel;
   logic signed [WS-1:0]         din_ext;
   logic signed [WS-1:0]         rnd_sum;
   logic signed [WS-1:0]         scaled;
   logic [WIDTH_OUT-1:0]         sat_dat;
   logic                         clip;

   logic                         s1_vld;
   logic [WIDTH_OUT-1:0]         s1_dat;

   logic [WIDTH_OUT-1:0]         mem [FIFO_DEPTH];
   logic [LOG2_FIFO_DEPTH-1:0]   wr_ptr;
   logic [LOG2_FIFO_DEPTH-1:0]   rd_ptr;
   logic [LOG2_FIFO_DEPTH:0]     count;
   logic                         full;
   logic                         push;
   logic                         pop;
   logic                         drop;

   assign sel = din_valid && (phase == '0);

   // One guard bit keeps din + rounding constant from overflowing before the shift.
   always_comb begin
      din_ext = {din[WIDTH_IN-1], din};
      rnd_sum = din_ext + RND;
      scaled  = rnd_sum >>> SHIFT;
      clip    = 1'b0;
      sat_dat = WIDTH_OUT'(scaled);
      if (scaled > MAXV) begin
         sat_dat = WIDTH_OUT'(MAXV);
         clip    = 1'b1;
      end else if (scaled < MINV) begin
         sat_dat = WIDTH_OUT'(MINV);
         clip    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase  <= '0;
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else begin
         if (din_valid)
            phase <= (phase == LOG2_DECIM'(DECIM - 1)) ? '0 : phase + 1'b1;
         s1_vld <= sel;
         if (sel)
            s1_dat <= sat_dat;
      end
   end

   assign dout_valid = (count != '0);
   assign dout       = mem[rd_ptr];
   assign full       = (count == (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH));
   assign pop        = dout_valid && dout_ready;
   // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
   assign push       = s1_vld && (!full || pop);
   assign drop       = s1_vld && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= s1_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // A set in the same edge as flag_clr wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (sel && clip)
            sat_flag <= 1'b1;
         else if (flag_clr)
            sat_flag <= 1'b0;
         if (drop)
            ovf_flag <= 1'b1;
         else if (flag_clr)
            ovf_flag <= 1'b0;
      end
   end

endmodule
